// File: rtl/pin_display_scanner_if.sv
// Display-side bundle between the PIN digit register and the 7-segment scanner.
// The master drives the digit/control inputs; the scanner (slave) drives the display pins.
interface pin_display_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [3:0]              digit_count;
  logic                    mask_en;
  logic                    blink_en;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output digits_in, digit_count, mask_en, blink_en,
    input  seg, an, frame_tick
  );

  modport slave (
    input  digits_in, digit_count, mask_en, blink_en,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/pin_display_scanner.sv
// Time-multiplexed 7-segment scanner for the keypad-lock PIN display.
// One digit per refresh slot, with a dead first cycle per slot, blanking, dash masking and alarm blink.
module pin_display_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  pin_display_scanner_if.slave   bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  logic [PW-1:0]         r_pres, w_pres_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [BW-1:0]         r_bcnt, w_bcnt_nxt;
  logic                  r_bph, w_bph_nxt;
  logic [6:0]            r_seg, w_seg_nxt;
  logic [NUM_DIGITS-1:0] r_an, w_an_nxt;
  logic                  r_tick, w_tick_nxt;

  logic                  w_dead;
  logic                  w_frame_start;
  logic [3:0]            w_nib;
  logic [3:0]            w_cnt_eff;

  always_comb begin
    w_dead        = (r_pres == '0);
    w_frame_start = w_dead && (r_idx == '0);

    w_pres_nxt = r_pres + PW'(1);
    w_idx_nxt  = r_idx;
    if (r_pres == PW'(REFRESH_DIV - 1)) begin
      w_pres_nxt = '0;
      w_idx_nxt  = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end

    // Blink counts whole frames; only runs while the alarm request is held.
    w_bcnt_nxt = r_bcnt;
    w_bph_nxt  = r_bph;
    if (!bus.blink_en) begin
      w_bcnt_nxt = '0;
      w_bph_nxt  = 1'b0;
    end else if (w_frame_start) begin
      if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
        w_bcnt_nxt = '0;
        w_bph_nxt  = ~r_bph;
      end else begin
        w_bcnt_nxt = r_bcnt + BW'(1);
      end
    end

    w_nib     = bus.digits_in[int'(r_idx)*4 +: 4];
    w_cnt_eff = (bus.digit_count > 4'(NUM_DIGITS)) ? 4'(NUM_DIGITS) : bus.digit_count;

    w_seg_nxt = SEG_BLANK;
    if (int'(r_idx) < int'(w_cnt_eff)) begin
      if (bus.mask_en) begin
        w_seg_nxt = SEG_DASH;
      end else begin
        case (w_nib)
          4'd0:    w_seg_nxt = 7'b1111110;
          4'd1:    w_seg_nxt = 7'b0110000;
          4'd2:    w_seg_nxt = 7'b1101101;
          4'd3:    w_seg_nxt = 7'b1111001;
          4'd4:    w_seg_nxt = 7'b0110011;
          4'd5:    w_seg_nxt = 7'b1011011;
          4'd6:    w_seg_nxt = 7'b1011111;
          4'd7:    w_seg_nxt = 7'b1110000;
          4'd8:    w_seg_nxt = 7'b1111111;
          4'd9:    w_seg_nxt = 7'b1111011;
          default: w_seg_nxt = SEG_BLANK;
        endcase
      end
    end

    w_an_nxt = NUM_DIGITS'(1) << r_idx;
    // Dead cycle hides segment switching between digits (anti-ghosting).
    if (w_dead || r_bph) begin
      w_an_nxt  = '0;
      w_seg_nxt = SEG_BLANK;
    end

    w_tick_nxt = w_frame_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pres <= '0;
      r_idx  <= '0;
      r_bcnt <= '0;
      r_bph  <= 1'b0;
      r_seg  <= '0;
      r_an   <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pres <= w_pres_nxt;
      r_idx  <= w_idx_nxt;
      r_bcnt <= w_bcnt_nxt;
      r_bph  <= w_bph_nxt;
      r_seg  <= w_seg_nxt;
      r_an   <= w_an_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_tick;
endmodule
